// File: rtl/node_tick_gen.sv
// node_tick_gen: sequences a network test run (node reset, traffic window,
// cooldown, done) and produces a per-node tick enable with a programmable
// period and phase for every node.

module node_tick_gen #(
    parameter int NUM_NODES       = 9,
    parameter int CNT_W           = 8,
    parameter int RESET_CYCLES    = 20,
    parameter int RUN_CYCLES      = 10000,
    parameter int COOLDOWN_CYCLES = 5000,
    parameter int DEFAULT_PERIOD  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_NODES)-1:0] cfg_node,
    input  logic [CNT_W-1:0]             cfg_period,
    input  logic [CNT_W-1:0]             cfg_phase,
    output logic                         cfg_err,
    output logic [NUM_NODES-1:0]         tick,
    output logic                         node_reset,
    output logic                         send,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  run_cycle
);

    // A zero-length window would never terminate, so it is stretched to one cycle.
    localparam int RST_LEN  = (RESET_CYCLES    < 1) ? 1 : RESET_CYCLES;
    localparam int RUN_LEN  = (RUN_CYCLES      < 1) ? 1 : RUN_CYCLES;
    localparam int COOL_LEN = (COOLDOWN_CYCLES < 1) ? 1 : COOLDOWN_CYCLES;
    localparam int MAX_A    = (RST_LEN > RUN_LEN) ? RST_LEN : RUN_LEN;
    localparam int MAX_LEN  = (MAX_A > COOL_LEN) ? MAX_A : COOL_LEN;
    localparam int DUR_W    = $clog2(MAX_LEN + 1);

    localparam logic [DUR_W-1:0] RST_LAST  = DUR_W'(RST_LEN - 1);
    localparam logic [DUR_W-1:0] RUN_LAST  = DUR_W'(RUN_LEN - 1);
    localparam logic [DUR_W-1:0] COOL_LAST = DUR_W'(COOL_LEN - 1);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);
    localparam logic [31:0]      RC_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        NRST,
        RUN,
        COOL,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DUR_W-1:0]       durCnt_q, durCnt_d;
    logic [CNT_W-1:0]       period_q [NUM_NODES];
    logic [CNT_W-1:0]       period_d [NUM_NODES];
    logic [CNT_W-1:0]       phase_q  [NUM_NODES];
    logic [CNT_W-1:0]       phase_d  [NUM_NODES];
    logic [CNT_W-1:0]       count_q  [NUM_NODES];
    logic [CNT_W-1:0]       count_d  [NUM_NODES];
    logic [NUM_NODES-1:0]   tick_q, tick_d;
    logic                   nodeReset_q, send_q, busy_q, done_q, cfgErr_q;
    logic [31:0]            runCycle_q;

    logic                   cfgHit, cfgValid, cfgAccept, launch;
    logic                   activeQ, activeD;

    assign cfgHit    = (state_q == IDLE) && cfg_we;
    assign cfgValid  = (int'(cfg_node) < NUM_NODES) && (cfg_period != '0) &&
                       (cfg_phase < cfg_period);
    assign cfgAccept = cfgHit && cfgValid;
    assign launch    = (state_q == IDLE) && start;
    assign activeQ   = (state_q == NRST) || (state_q == RUN) || (state_q == COOL);
    assign activeD   = (state_d == NRST) || (state_d == RUN) || (state_d == COOL);

    // Sequencer next state: each timed state counts its own length from zero.
    always_comb begin
        state_d  = state_q;
        durCnt_d = durCnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = NRST;
                    durCnt_d = '0;
                end
            end
            NRST: begin
                if (durCnt_q == RST_LAST) begin
                    state_d  = RUN;
                    durCnt_d = '0;
                end else begin
                    durCnt_d = durCnt_q + DUR_W'(1);
                end
            end
            RUN: begin
                if (durCnt_q == RUN_LAST) begin
                    state_d  = COOL;
                    durCnt_d = '0;
                end else begin
                    durCnt_d = durCnt_q + DUR_W'(1);
                end
            end
            COOL: begin
                if (durCnt_q == COOL_LAST) begin
                    state_d  = DONE;
                    durCnt_d = '0;
                end else begin
                    durCnt_d = durCnt_q + DUR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                durCnt_d = '0;
            end
        endcase
    end

    // Per-node config, phase counter and next tick; ticks use the post-write config.
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            period_d[i] = period_q[i];
            phase_d[i]  = phase_q[i];
            count_d[i]  = count_q[i];
            if (cfgAccept && (int'(cfg_node) == i)) begin
                period_d[i] = cfg_period;
                phase_d[i]  = cfg_phase;
            end
            if (launch) begin
                count_d[i] = '0;
            end else if (activeQ) begin
                if (count_q[i] >= period_q[i] - CNT_W'(1)) begin
                    count_d[i] = '0;
                end else begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end
            end
            tick_d[i] = activeD && (count_d[i] == phase_d[i]);
        end
    end

    // State, per-node registers and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            durCnt_q    <= '0;
            tick_q      <= '0;
            nodeReset_q <= 1'b0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfgErr_q    <= 1'b0;
            runCycle_q  <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                period_q[i] <= PERIOD_RST;
                phase_q[i]  <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            durCnt_q    <= durCnt_d;
            tick_q      <= tick_d;
            nodeReset_q <= (state_d == NRST);
            send_q      <= (state_d == RUN);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            cfgErr_q    <= cfgHit && !cfgValid;
            if (launch) begin
                runCycle_q <= '0;
            end else if ((state_q == RUN) && (runCycle_q != RC_MAX)) begin
                runCycle_q <= runCycle_q + 32'd1;
            end
            for (int i = 0; i < NUM_NODES; i++) begin
                period_q[i] <= period_d[i];
                phase_q[i]  <= phase_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    assign tick       = tick_q;
    assign node_reset = nodeReset_q;
    assign send       = send_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfgErr_q;
    assign run_cycle  = runCycle_q;

endmodule

// File: tb/tb_node_tick_gen.sv
// tb_node_tick_gen: drives short run sequences through node_tick_gen and
// compares every cycle of each run against an expected timeline queued up
// when the sequence is launched.

module tb_node_tick_gen;

    localparam int NN = 9;
    localparam int CW = 8;
    localparam int RC = 3;
    localparam int RN = 8;
    localparam int CD = 2;
    localparam int DP = 4;
    localparam int LAST = RC + RN + CD + 1;

    typedef struct packed {
        logic [NN-1:0] tick;
        logic          nrst;
        logic          send;
        logic          busy;
        logic          done;
        logic          err;
        logic [31:0]   rc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cfg_we;
    logic [3:0]    cfg_node;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_phase;
    logic          cfg_err;
    logic [NN-1:0] tick;
    logic          node_reset;
    logic          send;
    logic          busy;
    logic          done;
    logic [31:0]   run_cycle;

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelP [NN];
    int   modelH [NN];
    exp_t expQ [$];
    logic errQ [$];

    node_tick_gen #(
        .NUM_NODES(NN), .CNT_W(CW), .RESET_CYCLES(RC), .RUN_CYCLES(RN),
        .COOLDOWN_CYCLES(CD), .DEFAULT_PERIOD(DP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we),
        .cfg_node(cfg_node), .cfg_period(cfg_period), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .tick(tick), .node_reset(node_reset), .send(send),
        .busy(busy), .done(done), .run_cycle(run_cycle)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the bench itself ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: run did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic void model_defaults();
        for (int i = 0; i < NN; i++) begin
            modelP[i] = DP;
            modelH[i] = 0;
        end
    endfunction

    // Expected outputs in cycle k of a run launched by start in cycle 0;
    // r>0 means reset was held in cycle r, so everything after it is quiet.
    function automatic exp_t expect_cycle(input int k, input int r);
        exp_t e;
        logic active;
        e = '0;
        if (r > 0 && k > r) return e;
        active = (k >= 1) && (k <= RC + RN + CD);
        e.nrst = (k >= 1) && (k <= RC);
        e.send = (k > RC) && (k <= RC + RN);
        e.done = (k == LAST);
        e.busy = (k >= 1) && (k <= LAST);
        for (int i = 0; i < NN; i++)
            e.tick[i] = active && (((k - 1) % modelP[i]) == modelH[i]);
        if (k <= RC + 1) e.rc = 32'd0;
        else if (k - RC - 1 > RN) e.rc = 32'(RN);
        else e.rc = 32'(k - RC - 1);
        return e;
    endfunction

    function automatic exp_t observed();
        return {tick, node_reset, send, busy, done, cfg_err, run_cycle};
    endfunction

    // One config write issued in IDLE; the expected cfg_err is queued with it.
    task automatic cfg_write(input int node, input int period, input int phase);
        logic valid;
        logic got;
        logic want;
        valid = (node < NN) && (period >= 1) && (phase < period);
        cfg_we = 1'b1;
        cfg_node = 4'(node);
        cfg_period = CW'(period);
        cfg_phase = CW'(phase);
        errQ.push_back(!valid);
        if (valid) begin
            modelP[node] = period;
            modelH[node] = phase;
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        got = cfg_err;
        want = errQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL cfg_err node=%0d period=%0d phase=%0d: got %b want %b",
                     node, period, phase, got, want);
        end
        @(posedge clk); #1;
        testsRun++;
        if (cfg_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL cfg_err_pulse_width node=%0d: got %b want 0", node, cfg_err);
        end
    endtask

    // Launch one run and compare every cycle against the queued timeline,
    // optionally injecting a write, a second start or a reset mid-run.
    task automatic run_sequence(input string name, input int cfgCycle, input int startCycle,
                                input int resetCycle, input logic wrAtStart,
                                input int wrNode, input int wrP, input int wrH);
        exp_t got;
        exp_t want;
        if (wrAtStart) begin
            cfg_we = 1'b1;
            cfg_node = 4'(wrNode);
            cfg_period = CW'(wrP);
            cfg_phase = CW'(wrH);
            modelP[wrNode] = wrP;
            modelH[wrNode] = wrH;
        end
        start = 1'b1;
        for (int k = 1; k <= LAST + 1; k++) expQ.push_back(expect_cycle(k, resetCycle));
        for (int k = 1; k <= LAST + 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cfg_we = 1'b0;
            reset = 1'b0;
            got = observed();
            want = expQ.pop_front();
            testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL %s cycle %0d: got tick=%h nrst=%b send=%b busy=%b done=%b err=%b rc=%0d want tick=%h nrst=%b send=%b busy=%b done=%b err=%b rc=%0d",
                         name, k, got.tick, got.nrst, got.send, got.busy, got.done, got.err, got.rc,
                         want.tick, want.nrst, want.send, want.busy, want.done, want.err, want.rc);
            end
            if (k == cfgCycle) begin
                cfg_we = 1'b1;
                cfg_node = 4'd0;
                cfg_period = CW'(1);
                cfg_phase = CW'(0);
            end
            if (k == startCycle) start = 1'b1;
            if (k == resetCycle) reset = 1'b1;
        end
        if (resetCycle > 0) model_defaults();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_node = 4'd9;
        cfg_period = '0;
        cfg_phase = '0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (observed() !== exp_t'(0)) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got %h want 0", observed());
        end
        reset = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if (observed() !== exp_t'(0)) begin
            testsFailed++;
            $display("[TB] FAIL reset_priority: got %h want 0", observed());
        end
        model_defaults();
    endtask

    task automatic test_default_run();
        run_sequence("default_run", 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_phase_config();
        cfg_write(1, 4, 1);
        cfg_write(2, 1, 0);
        run_sequence("phase_config", 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_invalid_writes();
        cfg_write(0, 0, 0);
        cfg_write(4, 5, 5);
        cfg_write(NN, 2, 0);
        run_sequence("after_invalid", 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_cfg_during_run();
        run_sequence("cfg_in_run", RC + 3, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_start_during_run();
        run_sequence("start_in_run", 0, RC + 3, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_write_with_start();
        run_sequence("write_with_start", 0, 0, 0, 1'b1, 3, 3, 2);
    endtask

    task automatic test_mid_run_reset();
        run_sequence("mid_run_reset", 0, 0, RC + 6, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_sequence("post_reset_run", 0, 0, 0, 1'b0, 0, 0, 0);
        run_sequence("back_to_back", 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    // Scenario order matters: later runs rely on the config left by earlier ones.
    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_node = '0;
        cfg_period = '0;
        cfg_phase = '0;
        model_defaults();
        test_reset();
        test_default_run();
        test_phase_config();
        test_invalid_writes();
        test_cfg_during_run();
        test_start_during_run();
        test_write_with_start();
        test_mid_run_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/node_tick_gen.md
NODE_TICK_GEN -- requirements
Module: node_tick_gen

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_NODES, 9, number of node tick channels.
- CNT_W, 8, width of the per-node period and phase fields.
- RESET_CYCLES, 20, length of the node_reset hold.
- RUN_CYCLES, 10000, length of the send window.
- COOLDOWN_CYCLES, 5000, length of the drain window.
- DEFAULT_PERIOD, 4, per-node period loaded at reset.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a run sequence.
- cfg_we  in  1  config write strobe.
- cfg_node  in  $clog2(NUM_NODES)  target node.
- cfg_period  in  CNT_W  tick period in clk cycles.
- cfg_phase  in  CNT_W  tick offset within the period.
- cfg_err  out  1  one-cycle pulse marking a rejected write.
- tick  out  NUM_NODES  per-node one-cycle enable.
- node_reset  out  1  reset to the network under test.
- send  out  1  traffic-injection enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle end-of-sequence pulse.
- run_cycle  out  32  count of RUN cycles.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, NRST, RUN, COOL, DONE.
REQ-004 IDLE SHALL go to NRST on start=1; start SHALL be ignored in every other state.
REQ-005 NRST SHALL last exactly RESET_CYCLES cycles and then go to RUN.
REQ-006 RUN SHALL last exactly RUN_CYCLES cycles and then go to COOL.
REQ-007 COOL SHALL last exactly COOLDOWN_CYCLES cycles and then go to DONE.
REQ-008 DONE SHALL last 1 cycle and then go to IDLE.
REQ-009 All outputs SHALL be registered, with these values per state:
- node_reset=1 only in NRST.
- send=1 only in RUN.
- done=1 only in DONE.
- busy=1 in NRST, RUN, COOL and DONE.
REQ-010 Latency: start sampled at edge N SHALL give node_reset=1 and busy=1 from edge N+1.
REQ-011 Each node i SHALL hold a period register P_i, a phase register H_i and a counter c_i.
REQ-012 On entry to NRST, every c_i SHALL be 0.
REQ-013 In NRST, RUN and COOL, c_i SHALL increment each cycle and wrap from P_i-1 to 0.
REQ-014 In IDLE and DONE, c_i SHALL hold.
REQ-015 tick[i] SHALL be 1 exactly in cycles where c_i==H_i and the state is NRST, RUN or COOL; otherwise tick[i] SHALL be 0.
REQ-016 For P_i=1, tick[i] SHALL be continuously 1 throughout NRST, RUN and COOL.
REQ-017 A config write SHALL be accepted only if all of the following hold: state=IDLE, cfg_we=1, cfg_node<NUM_NODES, cfg_period>=1, cfg_phase<cfg_period.
REQ-018 An accepted write SHALL update P and H of node cfg_node from the next cycle.
REQ-019 cfg_we=1 in IDLE that fails any REQ-017 check SHALL leave all registers unchanged and pulse cfg_err one cycle later.
REQ-020 cfg_we=1 outside IDLE SHALL be ignored silently (cfg_err stays 0).
REQ-021 If start=1 and a valid cfg_we=1 occur in the same IDLE cycle, the write SHALL be applied and the run SHALL use the new values.
REQ-022 run_cycle SHALL clear to 0 on entry to NRST.
REQ-023 run_cycle SHALL increment once per RUN cycle, saturating at 2^32-1.
REQ-024 run_cycle SHALL hold its value from COOL until the next start.
REQ-025 Each per-state duration counter SHALL be wide enough for its parameter; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-026 reset=1 at any edge SHALL force, from the next cycle:
- state IDLE.
- every P_i=DEFAULT_PERIOD, H_i=0, c_i=0.
- tick=0, node_reset=0, send=0, busy=0, done=0, cfg_err=0, run_cycle=0.
REQ-027 reset SHALL take priority over start and cfg_we in the same cycle.
REQ-028 reset asserted mid-sequence SHALL abort the sequence without producing a done pulse.

Verification
REQ-029 Default run with RESET_CYCLES=3, RUN_CYCLES=8, COOLDOWN_CYCLES=2, start pulsed at cycle 0 -> all of:
- node_reset in cycles 1-3.
- send in cycles 4-11.
- done in cycle 14.
- run_cycle=8.
- every tick[i] at cycles 1,5,9,13.
REQ-030 Write node 1 period 4 phase 1, node 2 period 1 phase 0, then start -> tick[1] one cycle later than tick[0] each period; tick[2] high in every active cycle.
REQ-031 Invalid writes each pulse cfg_err with no register change:
- period 0.
- phase 5 with period 5.
- cfg_node=NUM_NODES.
REQ-032 cfg_we during RUN -> no cfg_err and no change to tick spacing.
REQ-033 start during RUN is ignored -> sequence timing unchanged.
REQ-034 reset asserted in cycle 6 of RUN -> next cycle all outputs 0 and busy=0; no done pulse.
